hex_display_scan_ctrl: RTL and testbench

Sequencer that shares one external combinational 4-bit-to-7-segment decoder (active-low, segment order a..g on bits [0:6]) among NDIG display digits.
- On a load handshake it captures a packed hex value.
- It presents the value to the shared decoder one nibble at a time, MSB digit first, and collects each decoded pattern.
- Optional leading-zero blanking.
- All digit patterns are committed to the HEX outputs atomically when the sequence ends.
- Sits between the datapath producing a number and the HEX0..HEX(NDIG-1) pins.

---
 rtl/hex_display_scan_ctrl.sv | 109 ++++++++++
 tb/tb_hex_display_scan_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_scan_ctrl.sv
// Time-multiplexes one external 7-segment decoder over NDIG digits, MSB first,
// with optional leading-zero blanking; hex_bus updates only when all digits are ready.
module hex_display_scan_ctrl #(
  parameter int NDIG    = 4,
  parameter int DEC_LAT = 1
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic [4*NDIG-1:0]   value,
  input  logic                load,
  input  logic                blank_lz,
  output logic                ready,
  output logic                done,
  output logic [3:0]          dec_bin,
  input  logic [6:0]          dec_seg,
  output logic [7*NDIG-1:0]   hex_bus
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int CW = $clog2(DEC_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t              state_q;
  logic [4*NDIG-1:0]   shadow_q;
  logic                lzb_q;
  logic                lz_active_q;
  logic [IW-1:0]       idx_q;
  logic [CW-1:0]       cnt_q;
  logic [7*NDIG-1:0]   work_q;
  logic [7*NDIG-1:0]   hex_bus_q;
  logic [3:0]          dec_bin_q;
  logic                ready_q;
  logic                done_q;

  logic [3:0]          cur_nib;
  logic                blank_digit;
  logic [7*NDIG-1:0]   work_d;

  // work_d already holds the digit captured this edge, so the commit to
  // hex_bus on the digit-0 edge includes it.
  always_comb begin
    cur_nib     = shadow_q[4*idx_q +: 4];
    blank_digit = lzb_q && lz_active_q && (cur_nib == 4'h0) && (idx_q != '0);
    work_d      = work_q;
    work_d[7*idx_q +: 7] = blank_digit ? 7'h7F : dec_seg;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= S_IDLE;
      shadow_q    <= '0;
      lzb_q       <= 1'b0;
      lz_active_q <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= '0;
      work_q      <= '1;
      hex_bus_q   <= '1;
      dec_bin_q   <= 4'h0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (load) begin
            shadow_q    <= value;
            lzb_q       <= blank_lz;
            lz_active_q <= 1'b1;
            idx_q       <= IW'(NDIG - 1);
            ready_q     <= 1'b0;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          dec_bin_q <= cur_nib;
          cnt_q     <= CW'(DEC_LAT);
          state_q   <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            work_q <= work_d;
            if (!blank_digit) lz_active_q <= 1'b0;
            if (idx_q == '0) begin
              hex_bus_q <= work_d;
              done_q    <= 1'b1;
              state_q   <= S_DONE;
            end else begin
              idx_q   <= idx_q - IW'(1);
              state_q <= S_ISSUE;
            end
          end
        end
        S_DONE: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready   = ready_q;
  assign done    = done_q;
  assign dec_bin = dec_bin_q;
  assign hex_bus = hex_bus_q;

endmodule

// File: tb/tb_hex_display_scan_ctrl.sv
// Bench for hex_display_scan_ctrl: a 4-digit/latency-1 and a 2-digit/latency-3
// instance share a clock and reset, each fed by a model 7-segment decoder.
module tb_hex_display_scan_ctrl;

  logic        clk;
  logic        rst_n;

  logic [15:0] value0;
  logic        load0, blank0, ready0, done0;
  logic [3:0]  dec_bin0;
  logic [6:0]  dec_seg0;
  logic [27:0] hex_bus0;

  logic [7:0]  value1;
  logic        load1, blank1, ready1, done1;
  logic [3:0]  dec_bin1;
  logic [6:0]  dec_seg1;
  logic [13:0] hex_bus1;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  hex_display_scan_ctrl #(.NDIG(4), .DEC_LAT(1)) u0 (
    .Clock(clk), .Resetn(rst_n), .value(value0), .load(load0), .blank_lz(blank0),
    .ready(ready0), .done(done0), .dec_bin(dec_bin0), .dec_seg(dec_seg0), .hex_bus(hex_bus0)
  );

  hex_display_scan_ctrl #(.NDIG(2), .DEC_LAT(3)) u1 (
    .Clock(clk), .Resetn(rst_n), .value(value1), .load(load1), .blank_lz(blank1),
    .ready(ready1), .done(done1), .dec_bin(dec_bin1), .dec_seg(dec_seg1), .hex_bus(hex_bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0001100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  default: return 7'b0111000;
    endcase
  endfunction

  assign dec_seg0 = seg7(dec_bin0);
  assign dec_seg1 = seg7(dec_bin1);

  // Expected display: walk digits from the most significant one, blanking
  // zeros until the first nonzero digit; digit 0 is always shown.
  function automatic logic [55:0] model(input logic [31:0] v, input logic b, input int nd);
    logic [55:0] r;
    bit still_leading;
    r = '0;
    still_leading = 1'b1;
    for (int i = nd - 1; i >= 0; i--) begin
      logic [3:0] n;
      n = 4'((v >> (4 * i)) & 32'hF);
      if (b && still_leading && n == 4'h0 && i != 0) begin
        r[7*i +: 7] = 7'h7F;
      end else begin
        r[7*i +: 7] = seg7(n);
        still_leading = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic logic [55:0] bus_of(input int sel);
    return (sel == 0) ? {28'h0, hex_bus0} : {42'h0, hex_bus1};
  endfunction
  function automatic logic rdy_of(input int sel);
    return (sel == 0) ? ready0 : ready1;
  endfunction
  function automatic logic done_of(input int sel);
    return (sel == 0) ? done0 : done1;
  endfunction
  function automatic logic [3:0] db_of(input int sel);
    return (sel == 0) ? dec_bin0 : dec_bin1;
  endfunction

  task automatic chk(input string tag, input logic [55:0] obs, input logic [55:0] exp);
    tot_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One load on instance sel; checks nibble sequence, done timing,
  // hex_bus stability and the final pattern. intr>0 pulses a stray load.
  task automatic run(input int sel, input logic [31:0] v, input logic b, input int intr);
    int nd, lat, total;
    logic [55:0] exp_bus, prev_bus;
    nd    = (sel == 0) ? 4 : 2;
    lat   = (sel == 0) ? 1 : 3;
    total = nd * (1 + lat);
    exp_bus = model(v, b, nd);
    for (int w = 0; w < 40 && !rdy_of(sel); w++) tick();
    chk("ready_before_load", 56'(rdy_of(sel)), 56'd1);
    prev_bus = bus_of(sel);
    if (sel == 0) begin value0 = v[15:0]; blank0 = b; load0 = 1'b1; end
    else          begin value1 = v[7:0];  blank1 = b; load1 = 1'b1; end
    tick();
    load0 = 1'b0;
    load1 = 1'b0;
    chk("ready_after_accept", 56'(rdy_of(sel)), 56'd0);
    for (int k = 1; k <= total + 1; k++) begin
      tick();
      if (k <= total) begin
        int dig;
        dig = nd - 1 - (k - 1) / (1 + lat);
        chk("dec_bin", 56'(db_of(sel)), 56'((v >> (4 * dig)) & 32'hF));
        chk("done_timing", 56'(done_of(sel)), 56'(k == total));
        if (k < total) chk("hex_bus_stable", bus_of(sel), prev_bus);
        else           chk("hex_bus_final", bus_of(sel), exp_bus);
      end else begin
        chk("done_after", 56'(done_of(sel)), 56'd0);
        chk("ready_after", 56'(rdy_of(sel)), 56'd1);
      end
      if (k == intr) begin
        value0 = 16'h9999;
        load0  = 1'b1;
      end else begin
        load0 = 1'b0;
      end
    end
    $display("load dut%0d value=%0h blank=%0b hex_bus=%0h expected=%0h",
             sel, v, b, bus_of(sel), exp_bus);
  endtask

  initial begin
    rst_n = 1'b0;
    value0 = '0; load0 = 1'b0; blank0 = 1'b0;
    value1 = '0; load1 = 1'b0; blank1 = 1'b0;
    tick();
    tick();
    chk("rst_hex_bus", 56'(hex_bus0), 56'hFFFFFFF);
    chk("rst_ready", 56'(ready0), 56'd1);
    chk("rst_done", 56'(done0), 56'd0);
    chk("rst_dec_bin", 56'(dec_bin0), 56'd0);
    chk("rst_hex_bus1", 56'(hex_bus1), 56'h3FFF);
    rst_n = 1'b1;
    tick();

    run(0, 32'h1234, 1'b0, 0);
    run(0, 32'h0070, 1'b1, 0);
    run(0, 32'h0105, 1'b1, 0);
    run(0, 32'h0000, 1'b1, 0);
    run(0, 32'h0000, 1'b0, 0);
    run(0, 32'hABCD, 1'b0, 3);

    // Reset during the third WAIT of a FFFF sequence
    for (int w = 0; w < 40 && !ready0; w++) tick();
    value0 = 16'hFFFF; blank0 = 1'b0; load0 = 1'b1;
    tick();
    load0 = 1'b0;
    repeat (5) tick();
    chk("mid_dec_bin", 56'(dec_bin0), 56'hF);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_hex_bus", 56'(hex_bus0), 56'hFFFFFFF);
    chk("mid_rst_ready", 56'(ready0), 56'd1);
    chk("mid_rst_dec_bin", 56'(dec_bin0), 56'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_rst_done", 56'(done0), 56'd0);
    end
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 56'(ready0), 56'd1);
    chk("post_rst_done", 56'(done0), 56'd0);
    run(0, 32'h1234, 1'b0, 0);

    run(1, 32'hE8, 1'b0, 0);
    run(1, 32'h05, 1'b1, 0);

    for (int i = 0; i < 12; i++) begin
      logic [31:0] rv;
      rv = $urandom & (32'hFFFF >> (4 * $urandom_range(0, 3)));
      run(0, rv, 1'($urandom_range(0, 1)), 0);
    end
    for (int i = 0; i < 6; i++) begin
      logic [31:0] rv;
      rv = $urandom & (32'hFF >> (4 * $urandom_range(0, 1)));
      run(1, rv, 1'($urandom_range(0, 1)), 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
